// File: rtl/heat_mode_if.sv
// Mode/thermostat request bundle and heater drive outputs
// for the heating-mode sequencer.
interface heat_mode_if #(
  parameter int N_MODES = 4,
  parameter int MODE_W  = $clog2(N_MODES),
  parameter int TEMP_W  = 8
);
  logic                enable;
  logic [MODE_W-1:0]   mode_req;
  logic                mode_req_valid;
  logic [TEMP_W-1:0]   temp;
  logic [TEMP_W-1:0]   setpoint;
  logic [N_MODES-1:0]  heater_en;
  logic [MODE_W-1:0]   active_mode;
  logic                busy;
  logic                req_err;

  modport master (
    output enable, mode_req, mode_req_valid,
    output temp, setpoint,
    input  heater_en, active_mode, busy, req_err
  );

  modport slave (
    input  enable, mode_req, mode_req_valid,
    input  temp, setpoint,
    output heater_en, active_mode, busy, req_err
  );
endinterface

// File: rtl/heat_mode_sequencer.sv
// N-way heating-mode sequencer: hysteresis thermostat, minimum
// on-time and an all-off dead time between heating systems.
module heat_mode_sequencer #(
  parameter int N_MODES       = 4,
  parameter int MODE_W        = $clog2(N_MODES),
  parameter int TEMP_W        = 8,
  parameter int HYST          = 2,
  parameter int MIN_ON_CYCLES = 64,
  parameter int DEAD_CYCLES   = 16
) (
  input  logic      clk,
  input  logic      rst,
  heat_mode_if.slave hm
);

  localparam int MIN_W  = $clog2(MIN_ON_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [MODE_W:0]     MODE_LIM = (MODE_W+1)'(N_MODES);
  localparam logic [TEMP_W:0]     HYST_X   = (TEMP_W+1)'(HYST);
  localparam logic [MIN_W-1:0]    MIN_LD   = MIN_W'(MIN_ON_CYCLES);
  localparam logic [DEAD_W-1:0]   DEAD_LD  = DEAD_W'(DEAD_CYCLES);
  localparam logic [MIN_W-1:0]    MIN_ONE  = MIN_W'(1);
  localparam logic [DEAD_W-1:0]   DEAD_ONE = DEAD_W'(1);
  localparam logic [N_MODES-1:0]  ONE_HOT0 = N_MODES'(1);

  typedef enum logic [1:0] {
    IDLE,
    HEAT,
    DEAD
  } state_t;

  state_t              state, state_n;
  logic [MODE_W-1:0]   active_mode, active_n;
  logic [MODE_W-1:0]   pending_mode, pmode_n;
  logic                pending, pend_n;
  logic                heat_demand, dem_n;
  logic [MIN_W-1:0]    min_cnt, min_n;
  logic [DEAD_W-1:0]   dead_cnt, dead_n;
  logic                req_err_q, err_n;

  logic [TEMP_W:0]     temp_x, sp_x;
  logic                dem_set, dem_clr;
  logic                in_range, req_ok;

  // One extra bit so temp+HYST and setpoint+HYST never wrap.
  assign temp_x  = {1'b0, hm.temp};
  assign sp_x    = {1'b0, hm.setpoint};
  assign dem_set = (temp_x + HYST_X) <= sp_x;
  assign dem_clr = temp_x >= (sp_x + HYST_X);

  assign in_range = {1'b0, hm.mode_req} < MODE_LIM;
  assign req_ok   = hm.mode_req_valid && in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      active_mode  <= '0;
      pending_mode <= '0;
      pending      <= 1'b0;
      heat_demand  <= 1'b0;
      min_cnt      <= '0;
      dead_cnt     <= '0;
      req_err_q    <= 1'b0;
    end else begin
      state        <= state_n;
      active_mode  <= active_n;
      pending_mode <= pmode_n;
      pending      <= pend_n;
      heat_demand  <= dem_n;
      min_cnt      <= min_n;
      dead_cnt     <= dead_n;
      req_err_q    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    active_n = active_mode;
    pmode_n  = pending_mode;
    pend_n   = pending;
    min_n    = min_cnt;
    dead_n   = dead_cnt;
    err_n    = hm.mode_req_valid && !in_range;
    dem_n    = heat_demand;

    unique case (1'b1)
      dem_set: dem_n = 1'b1;
      dem_clr: dem_n = 1'b0;
      default: dem_n = heat_demand;
    endcase

    unique case (state)
      IDLE: begin
        if (pending) begin
          active_n = pending_mode;
          pend_n   = 1'b0;
        end else if (hm.enable && heat_demand) begin
          state_n = HEAT;
          min_n   = MIN_LD;
        end
      end
      HEAT: begin
        min_n = (min_cnt == '0) ? '0 : min_cnt - MIN_ONE;
        if (!hm.enable ||
            (min_cnt == '0 && (!heat_demand || pending))) begin
          state_n = DEAD;
          dead_n  = DEAD_LD;
        end
      end
      DEAD: begin
        dead_n = (dead_cnt == '0) ? '0 : dead_cnt - DEAD_ONE;
        if (dead_cnt <= DEAD_ONE) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A new request overrides the clear from applying the old one.
    if (req_ok) begin
      if (hm.mode_req == active_n) begin
        pend_n = 1'b0;
      end else begin
        pend_n  = 1'b1;
        pmode_n = hm.mode_req;
      end
    end
  end

  assign hm.heater_en   = (state == HEAT) ? (ONE_HOT0 << active_mode)
                                          : '0;
  assign hm.active_mode = active_mode;
  assign hm.busy        = (state == DEAD) || pending;
  assign hm.req_err     = req_err_q;

endmodule

// File: tb/tb_heat_mode_sequencer.sv
// Bench for heat_mode_sequencer: directed scenarios plus random
// stimulus against a timestamp-based behavioural model.
module tb_heat_mode_sequencer;

  localparam int N     = 5;
  localparam int MW    = 3;
  localparam int TW    = 8;
  localparam int HY    = 2;
  localparam int MINON = 64;
  localparam int DEADC = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  heat_mode_if #(.N_MODES(N), .MODE_W(MW), .TEMP_W(TW)) hm ();

  heat_mode_sequencer #(
    .N_MODES(N), .MODE_W(MW), .TEMP_W(TW), .HYST(HY),
    .MIN_ON_CYCLES(MINON), .DEAD_CYCLES(DEADC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hm(hm)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(string name, int act, int lo, int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Model: heating/dead phases tracked by the edge index at which
  // they started or end, rather than by down-counters.
  bit m_heat, m_dead, m_pend, m_dem, m_err;
  int m_mode, m_pmode, heat_start, dead_end, cyc;
  int t_i, s_i, r_i;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_heat = 0; m_dead = 0; m_pend = 0; m_dem = 0; m_err = 0;
      m_mode = 0; m_pmode = 0; heat_start = 0; dead_end = 0;
      cyc = 0;
    end else begin
      cyc++;
      t_i = int'(hm.temp);
      s_i = int'(hm.setpoint);
      r_i = int'(hm.mode_req);
      if (m_heat) begin
        if (!hm.enable ||
            (cyc - heat_start > MINON && (!m_dem || m_pend))) begin
          m_heat = 0;
          m_dead = 1;
          dead_end = cyc + DEADC;
        end
      end else if (m_dead) begin
        if (cyc >= dead_end) m_dead = 0;
      end else if (m_pend) begin
        m_mode = m_pmode;
        m_pend = 0;
      end else if (hm.enable && m_dem) begin
        m_heat = 1;
        heat_start = cyc;
      end
      m_err = hm.mode_req_valid && r_i >= N;
      if (hm.mode_req_valid && r_i < N) begin
        if (r_i == m_mode) m_pend = 0;
        else begin
          m_pend = 1;
          m_pmode = r_i;
        end
      end
      if (t_i + HY <= s_i) m_dem = 1;
      else if (t_i >= s_i + HY) m_dem = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("heater_en", int'(hm.heater_en),
            m_heat ? (1 << m_mode) : 0);
      check("active_mode", int'(hm.active_mode), m_mode);
      check("busy", int'(hm.busy), int'(m_dead || m_pend));
      check("req_err", int'(hm.req_err), int'(m_err));
      check("onehot0", int'($onehot0(hm.heater_en)), 1);
    end
  end

  task automatic wait_on(string name);
    int k = 0;
    while (hm.heater_en == '0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(hm.heater_en != '0), 1);
  endtask

  initial begin
    int cnt;
    int v;
    rst = 1'b1;
    hm.enable = 1'b0;
    hm.mode_req = '0;
    hm.mode_req_valid = 1'b0;
    hm.temp = 8'd100;
    hm.setpoint = 8'd100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("rst_heater", int'(hm.heater_en), 0);
    check("rst_active", int'(hm.active_mode), 0);
    check("rst_busy", int'(hm.busy), 0);
    check("rst_err", int'(hm.req_err), 0);

    // Basic heat cycle with minimum on-time and dead time.
    hm.enable = 1'b1;
    hm.temp = 8'd98;
    @(negedge clk);
    check("lat_1cyc", int'(hm.heater_en), 0);
    @(negedge clk);
    check("lat_2cyc", int'(hm.heater_en), 5'b00001);
    hm.temp = 8'd102;
    cnt = 1;
    for (int i = 0; i < 200 && hm.heater_en != '0; i++) begin
      @(negedge clk);
      if (hm.heater_en != '0) cnt++;
    end
    check_rng("min_on", cnt, MINON, MINON + 1);
    cnt = 0;
    for (int i = 0; i < 100 && hm.busy; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("dead_len", cnt, DEADC);
    check("idle_off", int'(hm.heater_en), 0);

    // Mode change requested at HEAT cycle 10.
    hm.temp = 8'd98;
    wait_on("heat2_on");
    repeat (9) @(negedge clk);
    hm.mode_req = 3'd2;
    hm.mode_req_valid = 1'b1;
    @(negedge clk);
    hm.mode_req_valid = 1'b0;
    check("hold_mode0", int'(hm.heater_en), 5'b00001);
    check("busy_pend", int'(hm.busy), 1);
    for (int i = 0; i < 200 && hm.heater_en != '0; i++) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 100 && hm.heater_en == '0; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("switch_gap", cnt, DEADC + 2);
    check("mode2_on", int'(hm.heater_en), 5'b00100);
    check("mode2_act", int'(hm.active_mode), 2);

    // Enable drop at HEAT cycle 5 skips the minimum on-time.
    repeat (4) @(negedge clk);
    hm.enable = 1'b0;
    @(negedge clk);
    check("en_drop", int'(hm.heater_en), 0);
    cnt = 0;
    for (int i = 0; i < 100 && hm.busy; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("en_dead_len", cnt, DEADC);

    // Two requests during DEAD: the later one wins.
    hm.enable = 1'b1;
    wait_on("heat3_on");
    hm.enable = 1'b0;
    @(negedge clk);
    hm.mode_req = 3'd1;
    hm.mode_req_valid = 1'b1;
    @(negedge clk);
    hm.mode_req = 3'd3;
    @(negedge clk);
    hm.mode_req_valid = 1'b0;
    for (int i = 0; i < 100 && hm.busy; i++) @(negedge clk);
    check("latest_wins", int'(hm.active_mode), 3);
    check("busy_clear", int'(hm.busy), 0);

    // Out-of-range request.
    hm.mode_req = 3'd5;
    hm.mode_req_valid = 1'b1;
    @(negedge clk);
    hm.mode_req_valid = 1'b0;
    check("err_pulse", int'(hm.req_err), 1);
    @(negedge clk);
    check("err_once", int'(hm.req_err), 0);
    check("err_active", int'(hm.active_mode), 3);
    check("err_nopend", int'(hm.busy), 0);

    // Asynchronous reset between clock edges while heating.
    hm.enable = 1'b1;
    wait_on("heat4_on");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_heater", int'(hm.heater_en), 0);
    check("arst_active", int'(hm.active_mode), 0);
    check("arst_busy", int'(hm.busy), 0);
    check("arst_err", int'(hm.req_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Random phase.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      hm.enable = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 4))
          0: hm.setpoint = 8'd0;
          1: hm.setpoint = 8'd255;
          2: hm.setpoint = 8'd1;
          default: hm.setpoint = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 29) == 0) begin
        v = int'(hm.setpoint) + int'($urandom_range(0, 8)) - 4;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        hm.temp = v[7:0];
      end
      hm.mode_req_valid = ($urandom_range(0, 15) == 0);
      hm.mode_req = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    hm.mode_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/heat_mode_sequencer.md
Name: heat_mode_sequencer

Overview:
- Parametrised successor to the two-way heating-mode selector.
- Selects one of N_MODES heating systems and drives a one-hot enable vector.
- Runs a thermostat with hysteresis, a minimum on-time and an all-off dead time when switching between heating systems, so two systems are never driven together.
- Sits between the home-automation user/mode registers and the heater drive outputs.

Parameters:
- N_MODES, 4: number of heating systems; must be ≥2.
- MODE_W, $clog2(N_MODES): width of the mode index.
- TEMP_W, 8: width of temperature and setpoint (unsigned).
- HYST, 2: thermostat hysteresis in temperature LSBs.
- MIN_ON_CYCLES, 64: minimum cycles in HEAT before a voluntary exit.
- DEAD_CYCLES, 16: cycles held in DEAD (all heaters off) on every HEAT exit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  master heating enable
- mode_req  in  MODE_W  requested heating system index
- mode_req_valid  in  1  single-cycle strobe qualifying mode_req
- temp  in  TEMP_W  measured temperature
- setpoint  in  TEMP_W  target temperature
- heater_en  out  N_MODES  one-hot drive; all-zero when not heating
- active_mode  out  MODE_W  currently applied mode index
- busy  out  1  high while in DEAD or while a mode request is pending
- req_err  out  1  one-cycle pulse on an out-of-range request

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, heater_en=0, active_mode=0, pending cleared, heat_demand=0, both counters=0, busy=0, req_err=0.
  - Reset mid-HEAT forces heater_en to 0 immediately, without waiting for a clock edge.
- Thermostat (registered heat_demand):
  - Set when temp+HYST ≤ setpoint; cleared when temp ≥ setpoint+HYST; otherwise holds.
  - Compares are done at TEMP_W+1 bits, so there is no wrap-around at the extremes.
- Requests:
  - On mode_req_valid with mode_req < N_MODES: latch into pending_mode and set pending. If several requests arrive, the latest wins.
  - mode_req ≥ N_MODES: req_err=1 on the next cycle only; pending is unchanged.
  - A request equal to active_mode clears pending (no-op).
- State IDLE (heater_en=0):
  - If pending: active_mode←pending_mode and clear pending on the same edge; stay in IDLE that cycle.
  - Else if enable && heat_demand: go to HEAT and load min_cnt=MIN_ON_CYCLES.
- State HEAT (heater_en = one-hot of active_mode, registered from state):
  - min_cnt decrements each cycle and saturates at 0.
  - !enable: go to DEAD immediately. This safety path ignores min_cnt.
  - Else if min_cnt==0 and (!heat_demand or pending): go to DEAD.
  - On entering DEAD: load dead_cnt=DEAD_CYCLES; heater_en=0 from the next cycle.
- State DEAD (heater_en=0):
  - dead_cnt decrements each cycle.
  - When it reaches 0: go to IDLE, where any pending mode is applied.
- Latency:
  - temp crossing to heater_en rising is 2 cycles (thermostat register, then FSM).
  - After any HEAT exit, heater_en stays 0 for at least DEAD_CYCLES+1 cycles.
  - A changed mode is therefore never enabled earlier than DEAD_CYCLES+2 cycles after the old one drops.
- Simultaneous events:
  - A request arriving in the same cycle a pending mode is applied is latched as a new pending.
  - !enable takes priority over all other HEAT exits.
  - A request arriving during DEAD is applied in the IDLE that follows.
- Invariant: $onehot0(heater_en) in every cycle; active_mode never changes while heater_en≠0.

Test Plan (defaults; setpoint=100):
- Reset, then temp 98: heat_demand=1, heater_en=4'b0001 2 cycles later. temp 102: heater_en=0 only once 64 HEAT cycles have elapsed, followed by 16 DEAD cycles.
- While heating mode 0, request mode 2 at HEAT cycle 10: heater_en stays 0001 until cycle 64, then 0000 for ≥17 cycles, then 0100; active_mode=2.
- Requests 1 then 3 on consecutive cycles during DEAD: the final active_mode=3 (latest wins); busy stays high until it is applied.
- mode_req=5 with N_MODES=4: req_err pulses for one cycle; active_mode and pending are unchanged.
- enable drops at HEAT cycle 5: heater_en=0 the next cycle, ignoring the minimum on-time; DEAD lasts 16 cycles, then IDLE.
- Assert rst mid-HEAT between clock edges: heater_en=0 asynchronously; all outputs at reset values.
